// File: rtl/wb_stage_if.sv
// Execute-to-write-back handshake: execute drives valid code and payload,
// write-back returns ready.
interface wb_stage_if;
    logic [1:0]   es_to_ws_valid;
    logic [116:0] es_to_ws_bus;
    logic         ws_ready;

    modport master (
        output es_to_ws_valid,
        output es_to_ws_bus,
        input  ws_ready
    );

    modport slave (
        input  es_to_ws_valid,
        input  es_to_ws_bus,
        output ws_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: two-entry retire pipeline (W1 latch, W2 commit slot).
// W2 drives the register-file/CSR writes, the trace record and instret.
module wb_stage #(
    parameter bit TRACE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    wb_stage_if.slave    es,
    output logic [85:0]  forward_data1,
    output logic [85:0]  forward_data2,
    output logic         rf_we,
    output logic [4:0]   rf_waddr,
    output logic [31:0]  rf_wdata,
    output logic         csr_we,
    output logic [13:0]  csr_waddr,
    output logic [31:0]  csr_wdata,
    output logic         trace_valid,
    input  logic         trace_ready,
    output logic [31:0]  debug_wb_pc,
    output logic [3:0]   debug_wb_rf_we,
    output logic [4:0]   debug_wb_rf_wnum,
    output logic [31:0]  debug_wb_rf_wdata,
    output logic [63:0]  instret
);
    localparam int FORWAED_BUS_WD = 86;

    typedef struct packed {
        logic        csr_wen;
        logic [13:0] csr_addr;
        logic [31:0] csr_wdata;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ws_entry_t;

    function automatic logic [FORWAED_BUS_WD-1:0] fwd_pack(input logic vld, input ws_entry_t e);
        return {vld, e.csr_wen, e.csr_addr, e.csr_wdata, e.gr_we, e.dest, e.result};
    endfunction

    ws_entry_t ent_p0, ent_p1, ent_p2;
    logic      vld_p0, vld_p1, vld_p2;
    logic      retire, w2_free, ws_ready;

    assign ent_p0   = es.es_to_ws_bus;
    assign vld_p0   = (es.es_to_ws_valid == 2'b11);

    assign retire   = vld_p2 && (trace_ready || !TRACE_EN);
    assign w2_free  = !vld_p2 || retire;
    assign ws_ready = !vld_p1 || w2_free;
    assign es.ws_ready = ws_ready;

    // p0 -> p1: W1 latch; any non-11 valid code enters as a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            ent_p1 <= '0;
        end else if (ws_ready) begin
            vld_p1 <= vld_p0;
            ent_p1 <= ent_p0;
        end
    end

    // p1 -> p2: W2 commit slot, held while the trace consumer stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2 <= 1'b0;
            ent_p2 <= '0;
        end else if (w2_free) begin
            vld_p2 <= vld_p1;
            ent_p2 <= ent_p1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret <= 64'd0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end

    assign forward_data2     = fwd_pack(vld_p1, ent_p1);
    assign forward_data1     = fwd_pack(vld_p2, ent_p2);

    assign rf_we             = retire && ent_p2.gr_we && (ent_p2.dest != 5'd0);
    assign rf_waddr          = ent_p2.dest;
    assign rf_wdata          = ent_p2.result;

    assign csr_we            = retire && ent_p2.csr_wen;
    assign csr_waddr         = ent_p2.csr_addr;
    assign csr_wdata         = ent_p2.csr_wdata;

    assign trace_valid       = vld_p2;
    assign debug_wb_pc       = ent_p2.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = ent_p2.dest;
    assign debug_wb_rf_wdata = ent_p2.result;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic against a
// two-slot reference model and an in-order commit scoreboard.
module tb_wb_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_stage_if es();
    logic [85:0] forward_data1, forward_data2;
    logic        rf_we, csr_we, trace_valid, trace_ready;
    logic [4:0]  rf_waddr, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, csr_wdata, debug_wb_pc, debug_wb_rf_wdata;
    logic [13:0] csr_waddr;
    logic [3:0]  debug_wb_rf_we;
    logic [63:0] instret;

    wb_stage #(.TRACE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .es(es),
        .forward_data1(forward_data1), .forward_data2(forward_data2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .instret(instret)
    );

    typedef struct { bit vld; logic [116:0] bus; } ment_t;
    ment_t        m1, m2;
    logic [63:0]  m_instret;
    logic [116:0] acc_q[$];
    int           n_acc;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [116:0] mk(input logic [31:0] pc, input logic [31:0] res,
                                        input logic [4:0] dest, input logic gwe, input logic cwen,
                                        input logic [13:0] cadr, input logic [31:0] cwd);
        return {cwen, cadr, cwd, gwe, dest, res, pc};
    endfunction

    task automatic model_reset();
        m1.vld = 1'b0; m1.bus = '0;
        m2.vld = 1'b0; m2.bus = '0;
        m_instret = 64'd0;
        n_acc = 0;
        acc_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 128'(es.ws_ready), 128'(1));
        check({tag, "_fwd1"}, 128'(forward_data1), 128'(0));
        check({tag, "_fwd2"}, 128'(forward_data2), 128'(0));
        check({tag, "_rfport"}, 128'({rf_we, rf_waddr, rf_wdata}), 128'(0));
        check({tag, "_csrport"}, 128'({csr_we, csr_waddr, csr_wdata}), 128'(0));
        check({tag, "_trace"}, 128'({trace_valid, debug_wb_pc, debug_wb_rf_we,
                                     debug_wb_rf_wnum, debug_wb_rf_wdata}), 128'(0));
        check({tag, "_instret"}, 128'(instret), 128'(0));
    endtask

    // One clock cycle: present inputs, check outputs against the model, advance the model.
    task automatic step(input logic [1:0] v, input logic [116:0] b, input logic tr, output bit took);
        bit ret, wf, rdy, exp_rf;
        logic [116:0] head;
        es.es_to_ws_valid = v;
        es.es_to_ws_bus   = b;
        trace_ready       = tr;
        #1;
        ret    = m2.vld && tr;
        wf     = !m2.vld || ret;
        rdy    = !m1.vld || wf;
        exp_rf = ret && m2.bus[69] && (m2.bus[68:64] != 5'd0);
        check("ws_ready", 128'(es.ws_ready), 128'(rdy));
        check("trace_valid", 128'(trace_valid), 128'(m2.vld));
        check("instret", 128'(instret), 128'(m_instret));
        check("rf_we", 128'(rf_we), 128'(exp_rf));
        check("dbg_rf_we", 128'(debug_wb_rf_we), 128'({4{exp_rf}}));
        check("csr_we", 128'(csr_we), 128'(ret && m2.bus[116]));
        check("fwd1_vld", 128'(forward_data1[85]), 128'(m2.vld));
        check("fwd2_vld", 128'(forward_data2[85]), 128'(m1.vld));
        if (m2.vld) begin
            check("wb_pc", 128'(debug_wb_pc), 128'(m2.bus[31:0]));
            check("fwd1", 128'(forward_data1), 128'({1'b1, m2.bus[116:32]}));
            check("rf_port", 128'({rf_waddr, rf_wdata}), 128'({m2.bus[68:64], m2.bus[63:32]}));
            check("dbg_rf", 128'({debug_wb_rf_wnum, debug_wb_rf_wdata}), 128'({m2.bus[68:64], m2.bus[63:32]}));
            check("csr_port", 128'({csr_waddr, csr_wdata}), 128'(m2.bus[115:70]));
        end
        if (m1.vld)
            check("fwd2", 128'(forward_data2), 128'({1'b1, m1.bus[116:32]}));
        if (ret && acc_q.size() > 0) begin
            head = acc_q.pop_front();
            check("commit_order", 128'(debug_wb_pc), 128'(head[31:0]));
        end
        @(posedge clk);
        if (ret) m_instret = m_instret + 64'd1;
        if (wf)  m2 = m1;
        took = rdy && (v == 2'b11);
        if (rdy) begin
            m1.vld = (v == 2'b11);
            m1.bus = b;
        end
        if (took) begin
            acc_q.push_back(b);
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] v, input logic [116:0] b, input logic tr);
        bit took;
        int n;
        n = 0;
        do begin
            step(v, b, tr, took);
            n++;
        end while (!took && v == 2'b11 && n < 20);
        if (v == 2'b11 && !took) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout got=stalled expected=accepted");
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) send(2'b00, '0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [116:0] t3[4];
        logic [127:0] r;
        logic [116:0] rb;
        int           idx;
        bit           took;

        reset = 1'b0;
        es.es_to_ws_valid = 2'b00;
        es.es_to_ws_bus   = '0;
        trace_ready       = 1'b0;
        model_reset();
        #2;
        check_zero("rst0");
        @(negedge clk);
        reset = 1'b1;

        send(2'b11, mk(32'h1c000000, 32'h11, 5'd5, 1'b1, 1'b0, 14'h0, 32'h0), 1'b1);
        send(2'b11, mk(32'h1c000004, 32'h22, 5'd6, 1'b1, 1'b0, 14'h0, 32'h0), 1'b1);
        send(2'b11, mk(32'h1c000008, 32'h33, 5'd7, 1'b1, 1'b0, 14'h0, 32'h0), 1'b1);
        drain(3);
        check("t1_instret", 128'(instret), 128'(3));

        send(2'b01, mk(32'h1c00000c, 32'h44, 5'd8, 1'b1, 1'b0, 14'h0, 32'h0), 1'b1);
        #1;
        check("t2_fwd2_bubble", 128'(forward_data2[85]), 128'(0));
        send(2'b11, mk(32'h1c000010, 32'h55, 5'd9, 1'b1, 1'b0, 14'h0, 32'h0), 1'b1);
        drain(3);
        check("t2_instret", 128'(instret), 128'(4));

        for (int i = 0; i < 4; i++)
            t3[i] = mk(32'h1c000100 + 32'(4 * i), 32'h100 + 32'(i), 5'(10 + i), 1'b1, 1'b0, 14'h0, 32'h0);
        idx = 0;
        for (int c = 0; c < 16 && idx < 4; c++) begin
            step(2'b11, t3[idx], (c >= 4), took);
            if (c == 3) begin
                #1;
                check("t3_stall_ready", 128'(es.ws_ready), 128'(0));
                check("t3_fwd1_hold", 128'(forward_data1[31:0]), 128'(32'h100));
                check("t3_fwd2_hold", 128'(forward_data2[31:0]), 128'(32'h101));
            end
            if (took) idx++;
        end
        check("t3_sent", 128'(idx), 128'(4));
        drain(3);
        check("t3_instret", 128'(instret), 128'(8));

        send(2'b11, mk(32'h1c000200, 32'habcd, 5'd0, 1'b1, 1'b0, 14'h0, 32'h0), 1'b1);
        drain(3);
        check("t4_instret", 128'(instret), 128'(9));

        send(2'b11, mk(32'h1c000300, 32'h0, 5'd0, 1'b0, 1'b1, 14'h0006, 32'hdeadbeef), 1'b1);
        send(2'b11, mk(32'h1c000304, 32'h77, 5'd3, 1'b1, 1'b0, 14'h0, 32'h0), 1'b1);
        drain(3);

        send(2'b11, mk(32'h1c000400, 32'h88, 5'd4, 1'b1, 1'b0, 14'h0, 32'h0), 1'b0);
        send(2'b11, mk(32'h1c000404, 32'h99, 5'd5, 1'b1, 1'b1, 14'h12, 32'h5), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_zero("rst_async");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        drain(4);
        check("t6_instret", 128'(instret), 128'(0));

        for (int i = 0; i < 400; i++) begin
            r  = {$urandom, $urandom, $urandom, $urandom};
            rb = r[116:0];
            if ($urandom_range(0, 3) == 0) rb[68:64] = 5'd0;
            step(2'($urandom_range(0, 3)), rb, ($urandom_range(0, 9) < 7), took);
        end
        drain(4);
        check("final_instret", 128'(instret), 128'(n_acc));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
